// File: rtl/baud_ctrl.sv
// Baud-rate generator with shadowed divisor registers and a commit FSM.
// A divisor written to DLL/DLM only takes effect after a LOAD request, and
// the swap is deferred to a tick16 boundary so no tick period is truncated.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | active divisor stable, no commit requested
// PENDING | LOAD seen; active divisor is replaced on the next apply edge
module baud_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd177
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tick16,
    output logic       tick,
    output logic       busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dll_q, dll_d;
    logic [7:0]  dlm_q, dlm_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  sub_q, sub_d;
    logic        en_q, en_d;
    logic [7:0]  rdata_q, rdata_d;

    logic run;
    logic run_d;
    logic at_top;
    logic ctrl_wr;
    logic apply;

    // Counter is running only with a nonzero divisor and the enable set.
    assign run    = en_q && (div_q != 16'd0);
    assign at_top = (cnt_q == div_q - 16'd1);
    // Gated by reset so the outputs are quiet while reset is held, even
    // for a default divisor of 1 where cnt==div-1 holds at reset.
    assign tick16 = run && at_top && !reset;
    assign tick   = tick16 && (sub_q == 4'hF);
    assign busy   = (state_q == PENDING);
    assign rdata  = rdata_q;

    // Next-state logic for registers, commit FSM, counters and read data.
    always_comb begin
        ctrl_wr = wr_en && (addr == 2'd2);
        dll_d   = (wr_en && addr == 2'd0) ? wdata : dll_q;
        dlm_d   = (wr_en && addr == 2'd1) ? wdata : dlm_q;
        en_d    = ctrl_wr ? wdata[0] : en_q;

        // A stopped counter never produces tick16, so commit at once then.
        apply   = (state_q == PENDING) && (tick16 || !en_q || div_q == 16'd0);

        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_wr && wdata[1]) state_d = PENDING;
            PENDING: if (apply) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        div_d = apply ? {dlm_q, dll_q} : div_q;
        run_d = en_d && (div_d != 16'd0);

        if (!run_d || !run || apply || at_top) cnt_d = 16'd0;
        else                                   cnt_d = cnt_q + 16'd1;

        // sub survives a divisor change but not a stop.
        if (!run_d)      sub_d = 4'd0;
        else if (tick16) sub_d = sub_q + 4'd1;
        else             sub_d = sub_q;

        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = dll_q;
                2'd1:    rdata_d = dlm_q;
                2'd2:    rdata_d = {6'b0, busy, en_q};
                default: rdata_d = div_q[7:0];
            endcase
        end
    end

    // State registers; reset restores the default divisor and drops any commit.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dll_q   <= DEFAULT_DIV[7:0];
            dlm_q   <= DEFAULT_DIV[15:8];
            div_q   <= DEFAULT_DIV;
            en_q    <= 1'b1;
            cnt_q   <= 16'd0;
            sub_q   <= 4'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            dll_q   <= dll_d;
            dlm_q   <= dlm_d;
            div_q   <= div_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_baud_ctrl.sv
// Scoreboard bench for baud_ctrl: stimulus queues expected tick16 events
// (gap since previous tick16, tick flag) and expected read data; a monitor
// pops and compares whenever the DUT pulses tick16 or completes a read.
module tb_baud_ctrl;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [1:0] addr  = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       tick16;
    logic       tick;
    logic       busy;

    baud_ctrl #(.DEFAULT_DIV(16'd177)) dut (
        .clkin  (clkin),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .tick16 (tick16),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int   gap;   // 0 = gap not checked
        logic tk;
    } tev_t;

    tev_t       tq[$];
    logic [7:0] rq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_t   = 0;
    int         exp_sub  = 0;
    logic       rd_seen  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: edge bookkeeping.
    always @(posedge clkin) begin
        cyc++;
        rd_seen = rd_en;
        if (reset) last_t = cyc - 1;
    end

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clkin) begin
        if (tick && !tick16) check("tick_without_tick16", 1, 0);
        if (tick16) begin
            if (tq.size() == 0) begin
                check("unexpected_tick16", 1, 0);
            end else begin
                tev_t e;
                e = tq.pop_front();
                if (e.gap != 0) check("tick16_gap", cyc - last_t, e.gap);
                check("tick_flag", int'(tick), int'(e.tk));
            end
            last_t = cyc;
        end
        if (rd_seen) begin
            if (rq.size() == 0) check("unexpected_read", 1, 0);
            else                check("rdata", int'(rdata), int'(rq.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        rd_en = 1'b1; addr = a;
        rq.push_back(exp);
        step(1);
        rd_en = 1'b0;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
        rd_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        rq.push_back(exp);
        step(1);
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic mark();
        last_t = cyc - 1;
    endtask

    task automatic push_ticks(input int n, input int first_gap, input int gap);
        for (int i = 0; i < n; i++) begin
            tev_t e;
            e.gap   = (i == 0) ? first_gap : gap;
            e.tk    = (exp_sub == 15);
            exp_sub = (exp_sub + 1) % 16;
            tq.push_back(e);
        end
    endtask

    task automatic wait_empty(input int bound);
        int k;
        k = 0;
        while (tq.size() != 0 && k < bound) begin
            step(1);
            k++;
        end
        if (tq.size() != 0) begin
            check("tick16_timeout_left", tq.size(), 0);
            tq.delete();
        end
    endtask

    initial begin
        // Reset state
        step(2);
        @(negedge clkin);
        check("reset_rdata", int'(rdata), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tick16", int'(tick16), 0);
        check("reset_tick", int'(tick), 0);
        @(posedge clkin);
        #1 reset = 1'b0;

        // Default divisor 177: reads, then 16 tick16s with tick on the 16th
        exp_sub = 0;
        push_ticks(16, 177, 177);
        rd(2'd0, 8'hB1);
        rd(2'd1, 8'h00);
        rd(2'd2, 8'h01);
        rd(2'd3, 8'hB1);
        wait_empty(3000);

        // Mid-period commit of divisor 5; applies at the next tick16
        step(50);
        wr(2'd0, 8'h05);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h03);
        rd(2'd2, 8'h03);
        push_ticks(1, 177, 177);
        wait_empty(200);
        push_ticks(20, 5, 5);
        rd(2'd2, 8'h01);
        rd(2'd3, 8'h05);
        wait_empty(200);

        // Disabled commit applies immediately; then div=1 runs continuously
        wr(2'd2, 8'h00);
        exp_sub = 0;
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h02);
        rd(2'd2, 8'h02);
        rd(2'd3, 8'h01);
        rd(2'd2, 8'h00);
        step(20);
        wr(2'd2, 8'h01);
        mark();
        push_ticks(40, 1, 1);
        step(39);
        wr(2'd2, 8'h00);
        exp_sub = 0;
        wait_empty(20);

        // Commit divisor 0 while running, then recover with divisor 3
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h03);
        mark();
        push_ticks(1, 1, 1);
        wait_empty(20);
        exp_sub = 0;
        step(10);
        rd(2'd2, 8'h01);
        rd(2'd3, 8'h00);
        wr(2'd0, 8'h03);
        wr(2'd2, 8'h03);
        mark();
        push_ticks(5, 4, 3);
        step(14);
        wr(2'd0, 8'h05);
        step(1);
        wr(2'd2, 8'h03);
        check("busy_pending", int'(busy), 1);

        // Reset in the middle of the commit
        reset = 1'b1;
        #1;
        check("busy_after_reset", int'(busy), 0);
        wait_empty(5);
        step(3);
        @(negedge clkin);
        check("reset2_rdata", int'(rdata), 0);
        check("reset2_tick16", int'(tick16), 0);
        @(posedge clkin);
        #1 reset = 1'b0;
        exp_sub = 0;
        push_ticks(2, 177, 177);
        rd(2'd3, 8'hB1);
        rd(2'd2, 8'h01);
        rd(2'd0, 8'hB1);
        rd(2'd1, 8'h00);
        wait_empty(400);

        // Shadow rewritten while pending; second LOAD has no extra effect
        wr(2'd0, 8'h05);
        wr(2'd2, 8'h03);
        rd(2'd2, 8'h03);
        wr(2'd0, 8'h09);
        wr(2'd2, 8'h03);
        push_ticks(1, 177, 177);
        push_ticks(3, 9, 9);
        wait_empty(400);
        rd(2'd3, 8'h09);
        rd(2'd2, 8'h01);
        wr(2'd2, 8'h00);

        // Read and write to the same address returns the old value
        rdwr(2'd0, 8'h33, 8'h09);
        rd(2'd0, 8'h33);
        step(20);
        check("tick_queue_left", tq.size(), 0);
        check("read_queue_left", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 The block SHALL have a parameter DEFAULT_DIV, default 16'd177, which is the divisor loaded at reset (16x baud-tick period in clkin cycles).
REQ-002 The block SHALL have port clkin, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle.
REQ-005 The block SHALL have port rd_en, input, 1 bit: register read strobe.
REQ-006 The block SHALL have port addr, input, 2 bits: register select (0 = DLL, 1 = DLM, 2 = CTRL, 3 = ACTLO).
REQ-007 The block SHALL have port wdata, input, 8 bits: write data.
REQ-008 The block SHALL have port rdata, output, 8 bits: registered read data.
REQ-009 The block SHALL have port tick16, output, 1 bit: one-cycle pulse at 16x baud rate.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse at baud rate.
REQ-011 The block SHALL have port busy, output, 1 bit: a divisor commit is pending.

Function
REQ-012 DLL and DLM SHALL be shadow divisor bytes that can be written at any time, {DLM,DLL} forming the 16-bit shadow divisor; a shadow write SHALL NOT affect the active divisor.
REQ-013 CTRL bit0 SHALL be the enable bit (stored); CTRL bit1 SHALL be LOAD (write-only, self-clearing); all other CTRL bits SHALL be ignored on write.
REQ-014 The commit FSM SHALL have two states, IDLE and PENDING; in IDLE, a write of CTRL with LOAD=1 SHALL move it to PENDING and set busy=1 from the next cycle.
REQ-015 In PENDING, the active divisor SHALL be loaded from the shadow value present at the apply edge, and the FSM SHALL return to IDLE with busy=0 from the next cycle.
REQ-016 The apply edge SHALL be the edge ending a cycle with tick16=1, or the first edge in PENDING with enable=0 or active divisor = 0.
REQ-017 LOAD written while in PENDING SHALL have no additional effect; DLL/DLM writes made while in PENDING SHALL be included in the commit.
REQ-018 The 16-bit counter cnt SHALL count 0..div-1 while enable=1 and div!=0, wrapping to 0.
REQ-019 tick16 SHALL be 1 exactly during cycles where enable=1, div!=0 and cnt==div-1; with div=1, tick16 SHALL be continuously 1.
REQ-020 The 4-bit counter sub SHALL increment (mod 16) on each tick16; tick SHALL be 1 exactly in cycles where tick16=1 and sub==15.
REQ-021 With enable=0 or div=0, cnt and sub SHALL be held at 0 and tick16 and tick SHALL be held at 0.
REQ-022 After enable goes 0->1, the first tick16 SHALL occur div cycles after the enabling write edge.
REQ-023 When a new divisor is applied, cnt SHALL restart at 0 and sub SHALL continue counting (sub is not cleared).
REQ-024 On a cycle with rd_en=1, rdata SHALL load at the edge according to addr:
- 0: DLL shadow
- 1: DLM shadow
- 2: {6'b0, busy, enable}
- 3: active divisor [7:0]
REQ-025 On cycles with rd_en=0, rdata SHALL hold its value.
REQ-026 If wr_en and rd_en are both 1 to the same address, rdata SHALL return the pre-write value.

Reset
REQ-027 While reset=1, regardless of clkin, the block SHALL be forced to:
- DLL = DEFAULT_DIV[7:0], DLM = DEFAULT_DIV[15:8], active divisor = DEFAULT_DIV
- enable = 1, FSM = IDLE
- cnt = 0, sub = 0
- rdata = 0, tick16 = 0, tick = 0, busy = 0
REQ-028 Reset asserted mid-commit SHALL discard the pending commit and restore the active divisor to DEFAULT_DIV.

Verification
REQ-029 Release reset, idle -> first tick16 in the 177th cycle, tick16 period 177 cycles, first tick on the 16th tick16 (cycle 2832).
REQ-030 Write DLL=0x05, DLM=0x00, then CTRL=0x03 mid-period -> busy=1 until the next tick16, then tick16 period is 5 cycles and read addr 3 returns 0x05.
REQ-031 Write CTRL=0x00, then DLL=0x01 and CTRL=0x02 -> commit applies in 1 cycle, ticks stay 0; then write CTRL=0x01 -> tick16 is high every cycle and tick pulses every 16 cycles.
REQ-032 Commit divisor 0 -> tick16 and tick stay 0, busy clears; then commit 0x0003 -> ticks resume with period 3.
REQ-033 Assert reset while busy=1 after DLL=0x05 + LOAD -> busy=0, read addr 3 returns 0xB1, period is 177 again.
REQ-034 Rewrite DLL=0x09 while PENDING, before the apply edge -> applied divisor is 9, not the earlier shadow value.
